// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : CPU fetch port, CPU load/store port and unified memory bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) ();
    logic              i_ifReq;
    logic [ADDR_W-1:0] i_ifAddr;
    logic [DATA_W-1:0] o_ifInst;
    logic              o_ifValid;
    logic              o_ifStall;

    logic              i_dReadReq;
    logic              i_dWriteReq;
    logic [ADDR_W-1:0] i_dAddr;
    logic [SEL_W-1:0]  i_dSel;
    logic [DATA_W-1:0] i_dStoreData;
    logic [DATA_W-1:0] o_dLoadData;
    logic              o_dValid;
    logic              o_dStall;

    logic              o_memReadEnable;
    logic              o_memWriteEnable;
    logic [ADDR_W-1:0] o_memAddr;
    logic [SEL_W-1:0]  o_memSel;
    logic [DATA_W-1:0] o_memStoreData;
    logic [DATA_W-1:0] i_memLoadData;

    modport slave (
        input  i_ifReq, i_ifAddr, i_dReadReq, i_dWriteReq, i_dAddr, i_dSel,
               i_dStoreData, i_memLoadData,
        output o_ifInst, o_ifValid, o_ifStall, o_dLoadData, o_dValid, o_dStall,
               o_memReadEnable, o_memWriteEnable, o_memAddr, o_memSel, o_memStoreData
    );

    modport master (
        output i_ifReq, i_ifAddr, i_dReadReq, i_dWriteReq, i_dAddr, i_dSel,
               i_dStoreData, i_memLoadData,
        input  o_ifInst, o_ifValid, o_ifStall, o_dLoadData, o_dValid, o_dStall,
               o_memReadEnable, o_memWriteEnable, o_memAddr, o_memSel, o_memStoreData
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between fetch and load/store ports.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int MEM_LAT = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);
    localparam int              CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic             C_LAT_ONE  = (MEM_LAT == 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lastD;
    logic              r_isWrite;
    logic              r_memRe;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [SEL_W-1:0]  r_memSel;
    logic [DATA_W-1:0] r_memData;

    logic w_dReq;
    logic w_grantD;
    logic w_finalI;
    logic w_finalD;

    assign w_dReq   = bus.i_dReadReq | bus.i_dWriteReq;
    // On a collision the port that did not win last time is served.
    assign w_grantD = w_dReq & (~bus.i_ifReq | ~r_lastD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lastD   <= 1'b0;
            r_isWrite <= 1'b0;
            r_memRe   <= 1'b0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memSel  <= '0;
            r_memData <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_ifReq | w_dReq) begin
                        r_cnt     <= C_CNT_LOAD;
                        r_isWrite <= w_grantD & bus.i_dWriteReq;
                        r_memRe   <= ~(w_grantD & bus.i_dWriteReq);
                        r_memWe   <= w_grantD & bus.i_dWriteReq & C_LAT_ONE;
                        r_memAddr <= w_grantD ? bus.i_dAddr : bus.i_ifAddr;
                        r_memSel  <= w_grantD ? bus.i_dSel : {SEL_W{1'b1}};
                        r_memData <= w_grantD ? bus.i_dStoreData : '0;
                        r_state   <= w_grantD ? S_BUSY_D : S_BUSY_I;
                    end else begin
                        r_memRe <= 1'b0;
                        r_memWe <= 1'b0;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_memRe <= 1'b0;
                        r_memWe <= 1'b0;
                        r_lastD <= (r_state == S_BUSY_D);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // Write strobe lands on the last of the stable cycles.
                        if (r_cnt == CNT_W'(1)) begin
                            r_memWe <= r_isWrite;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_memRe <= 1'b0;
                    r_memWe <= 1'b0;
                end
            endcase
        end
    end

    assign w_finalI = (r_state == S_BUSY_I) && (r_cnt == '0);
    assign w_finalD = (r_state == S_BUSY_D) && (r_cnt == '0);

    assign bus.o_ifValid        = w_finalI;
    assign bus.o_dValid         = w_finalD;
    assign bus.o_ifInst         = w_finalI ? bus.i_memLoadData : '0;
    assign bus.o_dLoadData      = (w_finalD && !r_isWrite) ? bus.i_memLoadData : '0;
    assign bus.o_ifStall        = bus.i_ifReq & ~w_finalI;
    assign bus.o_dStall         = w_dReq & ~w_finalD;
    assign bus.o_memReadEnable  = r_memRe;
    assign bus.o_memWriteEnable = r_memWe;
    assign bus.o_memAddr        = r_memAddr;
    assign bus.o_memSel         = r_memSel;
    assign bus.o_memStoreData   = r_memData;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed plus randomized check of mem_arbiter against a
//            transaction-level schedule model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Small word memory, aliased on address bits [5:2].
    logic [31:0] mem [16];
    assign bus.i_memLoadData = mem[bus.o_memAddr[5:2]];
    always @(posedge clk) begin
        if (bus.o_memWriteEnable) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_memSel[b]) mem[bus.o_memAddr[5:2]][8*b +: 8] <= bus.o_memStoreData[8*b +: 8];
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    // Transaction model: one access in flight, finishing LAT cycles after grant.
    int          cyc = 0;
    int          m_done = 0;
    bit          m_busy = 0, m_ownD = 0, m_lastD = 0, m_wr = 0;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_sel;
    bit          e_vi = 0, e_vd = 0;
    int          cnt_vi, cnt_vd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        @(negedge clk);
        e_vi = m_busy && !m_ownD && (cyc == m_done);
        e_vd = m_busy &&  m_ownD && (cyc == m_done);
        chk("ifValid", 32'(bus.o_ifValid), 32'(e_vi));
        chk("dValid",  32'(bus.o_dValid),  32'(e_vd));
        chk("ifStall", 32'(bus.o_ifStall), 32'(bus.i_ifReq && !e_vi));
        chk("dStall",  32'(bus.o_dStall),  32'((bus.i_dReadReq || bus.i_dWriteReq) && !e_vd));
        chk("memRe",   32'(bus.o_memReadEnable),  32'(m_busy && (!m_ownD || !m_wr)));
        chk("memWe",   32'(bus.o_memWriteEnable), 32'(m_busy && m_wr && (cyc == m_done)));
        if (m_busy) begin
            chk("memAddr", bus.o_memAddr, m_addr);
            chk("memSel",  32'(bus.o_memSel), 32'(m_sel));
            if (m_wr) chk("memData", bus.o_memStoreData, m_data);
        end
        if (e_vi) chk("ifInst", bus.o_ifInst, mem[m_addr[5:2]]);
        if (e_vd && !m_wr) chk("dLoad", bus.o_dLoadData, mem[m_addr[5:2]]);
        if (bus.o_ifValid) cnt_vi++;
        if (bus.o_dValid)  cnt_vd++;
    endtask

    task automatic advance();
        bit dreq, gd;
        @(posedge clk);
        dreq = bus.i_dReadReq || bus.i_dWriteReq;
        if (rst) begin
            if (m_busy) begin
                if (cyc == m_done) begin
                    m_busy  = 0;
                    m_lastD = m_ownD;
                end
            end else if (bus.i_ifReq || dreq) begin
                gd     = dreq && (!bus.i_ifReq || !m_lastD);
                m_busy = 1;
                m_ownD = gd;
                m_done = cyc + LAT;
                m_wr   = gd && bus.i_dWriteReq;
                m_addr = gd ? bus.i_dAddr : bus.i_ifAddr;
                m_sel  = gd ? bus.i_dSel : 4'hF;
                m_data = bus.i_dStoreData;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic set_rst(input bit v);
        rst = v;
        if (!v) begin
            m_busy  = 0;
            m_lastD = 0;
        end
    endtask

    // mode 0: random traffic, 1: both ports always requesting, 2: drop on completion only
    task automatic drive(input int mode);
        if (bus.i_ifReq && e_vi) begin
            bus.i_ifReq  = (mode == 1);
            bus.i_ifAddr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end else if (!bus.i_ifReq && mode == 0 && $urandom_range(0, 2) == 0) begin
            bus.i_ifReq  = 1;
            bus.i_ifAddr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end
        if ((bus.i_dReadReq || bus.i_dWriteReq) && e_vd) begin
            bus.i_dReadReq  = (mode == 1);
            bus.i_dWriteReq = 0;
            bus.i_dAddr     = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end else if (!(bus.i_dReadReq || bus.i_dWriteReq) && mode == 0 && $urandom_range(0, 2) == 0) begin
            bus.i_dWriteReq  = $urandom_range(0, 1);
            bus.i_dReadReq   = !bus.i_dWriteReq || ($urandom_range(0, 3) == 0);
            bus.i_dAddr      = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            bus.i_dSel       = 4'($urandom_range(1, 15));
            bus.i_dStoreData = $urandom;
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            check_cycle();
            advance();
            drive(mode);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        set_rst(0);
        bus.i_ifReq = 1; bus.i_ifAddr = 32'h0;
        bus.i_dReadReq = 1; bus.i_dWriteReq = 1; bus.i_dAddr = 32'h0;
        bus.i_dSel = 4'hF; bus.i_dStoreData = 32'h0;

        // Reset with both ports requesting: nothing moves, both stalled.
        run(3, 2);
        chk("rstAddr", bus.o_memAddr, 32'h0);
        chk("rstSel",  32'(bus.o_memSel), 32'h0);
        chk("rstInst", bus.o_ifInst, 32'h0);
        chk("rstLoad", bus.o_dLoadData, 32'h0);
        bus.i_ifReq = 0; bus.i_dReadReq = 0; bus.i_dWriteReq = 0;
        set_rst(1);
        run(2, 2);

        // Single fetch from 0x4.
        mem[1] = 32'h3C010101;
        bus.i_ifReq = 1; bus.i_ifAddr = 32'h4;
        run(5, 2);

        // Collision right after reset: data first, fetch three cycles later.
        set_rst(0);
        run(1, 2);
        set_rst(1);
        bus.i_ifReq = 1; bus.i_ifAddr = 32'h0;
        bus.i_dReadReq = 1; bus.i_dAddr = 32'h100; bus.i_dSel = 4'hF;
        run(8, 2);

        // Half-word store, then read it back.
        bus.i_dWriteReq = 1; bus.i_dAddr = 32'h200; bus.i_dSel = 4'b0011;
        bus.i_dStoreData = 32'hDEADBEEF;
        run(4, 2);
        bus.i_dReadReq = 1; bus.i_dAddr = 32'h200; bus.i_dSel = 4'hF;
        run(4, 2);

        // Reset during a store: no write, restarts after release.
        bus.i_dWriteReq = 1; bus.i_dAddr = 32'h204; bus.i_dSel = 4'hF;
        bus.i_dStoreData = 32'h12345678;
        run(1, 2);
        set_rst(0);
        run(2, 2);
        set_rst(1);
        run(6, 2);

        // Both ports saturating: one completion every three cycles, alternating.
        cnt_vi = 0; cnt_vd = 0;
        bus.i_ifReq = 1; bus.i_dReadReq = 1;
        run(30, 1);
        chk("satFetchCount", 32'(cnt_vi), 32'd5);
        chk("satDataCount",  32'(cnt_vd), 32'd5);
        bus.i_ifReq = 0; bus.i_dReadReq = 0; bus.i_dWriteReq = 0;
        run(4, 2);

        // Random traffic with occasional asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                set_rst(0);
                run(1, 0);
                set_rst(1);
            end
            run(1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
